// File: rtl/cond_branch.sv
// cond_branch: pairs a data stream with a condition stream through two
// independent circular queues and steers each data word to the true or
// false output path depending on its paired condition.
module cond_branch #(
    parameter int N     = 16,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic         R_IN_D,
    input  logic [N-1:0] D_IN,
    input  logic         R_IN_C,
    input  logic [N-1:0] C_IN,
    output logic         R_OUT_T,
    output logic [N-1:0] D_OUT_T,
    output logic         R_OUT_F,
    output logic [N-1:0] D_OUT_F,
    output logic         ERR
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);

    logic [N-1:0]   r_dq [DEPTH];
    logic [DEPTH-1:0] r_cq;
    logic [AW-1:0]  r_dwp;
    logic [AW-1:0]  r_drp;
    logic [AW-1:0]  r_cwp;
    logic [AW-1:0]  r_crp;
    logic [AW:0]    r_dcnt;
    logic [AW:0]    r_ccnt;
    logic           r_rt;
    logic           r_rf;
    logic [N-1:0]   r_dt;
    logic [N-1:0]   r_df;
    logic           r_err;

    logic           w_pop;
    logic           w_dfull;
    logic           w_cfull;
    logic           w_dpush;
    logic           w_cpush;
    logic           w_ovf;
    logic [N-1:0]   w_dhead;
    logic           w_chead;

    // Pop/push decisions from registered occupancy only; a full queue
    // still accepts a push when the same edge pops it.
    always_comb begin
        w_pop   = EN && (r_dcnt != '0) && (r_ccnt != '0);
        w_dfull = (r_dcnt == C_FULL);
        w_cfull = (r_ccnt == C_FULL);
        w_dpush = EN && R_IN_D && (!w_dfull || w_pop);
        w_cpush = EN && R_IN_C && (!w_cfull || w_pop);
        w_ovf   = EN && ((R_IN_D && w_dfull && !w_pop) ||
                         (R_IN_C && w_cfull && !w_pop));
        w_dhead = r_dq[r_drp];
        w_chead = r_cq[r_crp];
    end

    // Queue storage writes; contents need no reset since occupancy gates reads.
    always_ff @(posedge CLK) begin
        if (!RST && w_dpush) begin
            r_dq[r_dwp] <= D_IN;
        end
        if (!RST && w_cpush) begin
            r_cq[r_cwp] <= (C_IN != '0);
        end
    end

    // Pointer and occupancy bookkeeping for both queues.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dwp  <= '0;
            r_drp  <= '0;
            r_cwp  <= '0;
            r_crp  <= '0;
            r_dcnt <= '0;
            r_ccnt <= '0;
        end else begin
            if (w_dpush) r_dwp <= r_dwp + 1'b1;
            if (w_cpush) r_cwp <= r_cwp + 1'b1;
            if (w_pop) begin
                r_drp <= r_drp + 1'b1;
                r_crp <= r_crp + 1'b1;
            end
            case ({w_dpush, w_pop})
                2'b10:   r_dcnt <= r_dcnt + 1'b1;
                2'b01:   r_dcnt <= r_dcnt - 1'b1;
                default: r_dcnt <= r_dcnt;
            endcase
            case ({w_cpush, w_pop})
                2'b10:   r_ccnt <= r_ccnt + 1'b1;
                2'b01:   r_ccnt <= r_ccnt - 1'b1;
                default: r_ccnt <= r_ccnt;
            endcase
        end
    end

    // Route a popped pair to the true or false path; strobes last one cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rt <= 1'b0;
            r_rf <= 1'b0;
            r_dt <= '0;
            r_df <= '0;
        end else if (w_pop) begin
            if (w_chead) begin
                r_rt <= 1'b1;
                r_rf <= 1'b0;
                r_dt <= w_dhead;
            end else begin
                r_rt <= 1'b0;
                r_rf <= 1'b1;
                r_df <= w_dhead;
            end
        end else if (EN) begin
            r_rt <= 1'b0;
            r_rf <= 1'b0;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_ovf) begin
            r_err <= 1'b1;
        end
    end

    assign R_OUT_T = r_rt;
    assign D_OUT_T = r_dt;
    assign R_OUT_F = r_rf;
    assign D_OUT_F = r_df;
    assign ERR     = r_err;

endmodule

// File: tb/tb_cond_branch.sv
// tb_cond_branch: directed scenarios plus randomized traffic for cond_branch,
// checked every cycle against a queue-based reference model.
module tb_cond_branch;

    localparam int N     = 16;
    localparam int DEPTH = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         EN  = 1'b0;
    logic         R_IN_D = 1'b0;
    logic [N-1:0] D_IN = '0;
    logic         R_IN_C = 1'b0;
    logic [N-1:0] C_IN = '0;
    logic         R_OUT_T;
    logic [N-1:0] D_OUT_T;
    logic         R_OUT_F;
    logic [N-1:0] D_OUT_F;
    logic         ERR;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [N-1:0] m_dq[$];
    bit           m_cq[$];
    logic         m_rt = 1'b0;
    logic         m_rf = 1'b0;
    logic [N-1:0] m_dt = '0;
    logic [N-1:0] m_df = '0;
    logic         m_err = 1'b0;

    cond_branch #(.N(N), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .EN(EN),
        .R_IN_D(R_IN_D), .D_IN(D_IN),
        .R_IN_C(R_IN_C), .C_IN(C_IN),
        .R_OUT_T(R_OUT_T), .D_OUT_T(D_OUT_T),
        .R_OUT_F(R_OUT_F), .D_OUT_F(D_OUT_F),
        .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one edge using the inputs present at that edge.
    task automatic model_edge();
        bit pop, dfull, cfull, cv;
        logic [N-1:0] dv;
        if (RST) begin
            m_dq.delete(); m_cq.delete();
            m_rt = 0; m_rf = 0; m_dt = '0; m_df = '0; m_err = 0;
        end else if (EN) begin
            pop   = (m_dq.size() > 0) && (m_cq.size() > 0);
            dfull = (m_dq.size() == DEPTH);
            cfull = (m_cq.size() == DEPTH);
            m_rt = 0; m_rf = 0;
            if (pop) begin
                dv = m_dq.pop_front();
                cv = m_cq.pop_front();
                if (cv) begin m_rt = 1; m_dt = dv; end
                else    begin m_rf = 1; m_df = dv; end
            end
            if (R_IN_D) begin
                if (!dfull || pop) m_dq.push_back(D_IN); else m_err = 1;
            end
            if (R_IN_C) begin
                if (!cfull || pop) m_cq.push_back(C_IN != '0); else m_err = 1;
            end
        end
    endtask

    // One clock edge: update model, then compare all outputs 1 time unit later.
    task automatic cyc();
        @(posedge CLK);
        model_edge();
        #1;
        chk("R_OUT_T", {{(N-1){1'b0}}, R_OUT_T}, {{(N-1){1'b0}}, m_rt});
        chk("R_OUT_F", {{(N-1){1'b0}}, R_OUT_F}, {{(N-1){1'b0}}, m_rf});
        chk("D_OUT_T", D_OUT_T, m_dt);
        chk("D_OUT_F", D_OUT_F, m_df);
        chk("ERR", {{(N-1){1'b0}}, ERR}, {{(N-1){1'b0}}, m_err});
        chk("exclusive", {{(N-1){1'b0}}, R_OUT_T & R_OUT_F}, '0);
    endtask

    task automatic idle();
        R_IN_D = 0; R_IN_C = 0; D_IN = '0; C_IN = '0;
    endtask

    task automatic do_reset();
        RST = 1; idle(); cyc(); RST = 0;
    endtask

    initial begin
        // Reset state
        RST = 1; EN = 1; idle();
        cyc(); cyc();
        chk("rst_rt", {15'd0, R_OUT_T}, 16'd0);
        chk("rst_rf", {15'd0, R_OUT_F}, 16'd0);
        chk("rst_dt", D_OUT_T, 16'h0000);
        chk("rst_df", D_OUT_F, 16'h0000);
        chk("rst_err", {15'd0, ERR}, 16'd0);
        RST = 0;

        // Pairing: both tokens at edge 0, strobe after edge 1
        R_IN_D = 1; D_IN = 16'h00AA; R_IN_C = 1; C_IN = 16'h0001;
        cyc();
        idle();
        chk("pair_nostrobe_e0", {15'd0, R_OUT_T}, 16'd0);
        cyc();
        chk("pair_rt", {15'd0, R_OUT_T}, 16'd1);
        chk("pair_dt", D_OUT_T, 16'h00AA);
        chk("pair_rf", {15'd0, R_OUT_F}, 16'd0);
        cyc();
        chk("pair_rt_drop", {15'd0, R_OUT_T}, 16'd0);

        // Skew: data at edge 0, condition 0 at edge 3
        R_IN_D = 1; D_IN = 16'h1234;
        cyc(); idle();
        cyc();
        chk("skew_none_e1", {14'd0, R_OUT_T, R_OUT_F}, 16'd0);
        cyc();
        chk("skew_none_e2", {14'd0, R_OUT_T, R_OUT_F}, 16'd0);
        R_IN_C = 1; C_IN = 16'h0000;
        cyc(); idle();
        chk("skew_none_e3", {14'd0, R_OUT_T, R_OUT_F}, 16'd0);
        cyc();
        chk("skew_rf", {15'd0, R_OUT_F}, 16'd1);
        chk("skew_df", D_OUT_F, 16'h1234);
        chk("skew_dt_held", D_OUT_T, 16'h00AA);

        // Streaming: 8 pairs back to back, alternating T/F
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                R_IN_D = 1; D_IN = 16'h0100 + 16'(i);
                R_IN_C = 1; C_IN = (i % 2 == 0) ? 16'h8000 : 16'h0000;
            end else idle();
            cyc();
            if (i >= 1) begin
                if ((i - 1) % 2 == 0) begin
                    chk("stream_rt", {15'd0, R_OUT_T}, 16'd1);
                    chk("stream_dt", D_OUT_T, 16'h0100 + 16'(i - 1));
                end else begin
                    chk("stream_rf", {15'd0, R_OUT_F}, 16'd1);
                    chk("stream_df", D_OUT_F, 16'h0100 + 16'(i - 1));
                end
            end
        end
        idle();
        chk("stream_err", {15'd0, ERR}, 16'd0);
        cyc();

        // Overflow: 5 data tokens into a 4-deep queue
        do_reset();
        for (int i = 0; i < 5; i++) begin
            R_IN_D = 1; D_IN = 16'h0200 + 16'(i);
            cyc();
            if (i == 3) chk("ovf_err_before", {15'd0, ERR}, 16'd0);
        end
        idle();
        chk("ovf_err", {15'd0, ERR}, 16'd1);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin R_IN_C = 1; C_IN = 16'h0003; end else idle();
            cyc();
            if (i >= 1) begin
                chk("ovf_rt", {15'd0, R_OUT_T}, 16'd1);
                chk("ovf_dt", D_OUT_T, 16'h0200 + 16'(i - 1));
            end
        end
        cyc();
        chk("ovf_drained", {15'd0, R_OUT_T}, 16'd0);
        chk("ovf_err_sticky", {15'd0, ERR}, 16'd1);

        // Freeze: EN=0 while a strobe is high
        do_reset();
        R_IN_D = 1; D_IN = 16'h0300; R_IN_C = 1; C_IN = 16'h0001;
        cyc();
        R_IN_C = 0; D_IN = 16'h0301;
        cyc();
        chk("frz_rt_pre", {15'd0, R_OUT_T}, 16'd1);
        EN = 0; R_IN_D = 1; D_IN = 16'h0999; R_IN_C = 1; C_IN = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("frz_rt_held", {15'd0, R_OUT_T}, 16'd1);
            chk("frz_dt_held", D_OUT_T, 16'h0300);
        end
        EN = 1; idle(); R_IN_C = 1; C_IN = 16'h0000;
        cyc(); idle();
        chk("frz_resume_none", {14'd0, R_OUT_T, R_OUT_F}, 16'd0);
        cyc();
        chk("frz_resume_rf", {15'd0, R_OUT_F}, 16'd1);
        chk("frz_resume_df", D_OUT_F, 16'h0301);
        cyc();
        chk("frz_nothing_left", {14'd0, R_OUT_T, R_OUT_F}, 16'd0);

        // Reset mid-operation discards queued data
        do_reset();
        for (int i = 0; i < 3; i++) begin
            R_IN_D = 1; D_IN = 16'h0400 + 16'(i); cyc();
        end
        idle(); RST = 1;
        cyc();
        RST = 0;
        chk("mid_rst_all0", {13'd0, R_OUT_T, R_OUT_F, ERR}, 16'd0);
        chk("mid_rst_dt", D_OUT_T, 16'h0000);
        R_IN_C = 1; C_IN = 16'h0001;
        cyc(); idle();
        cyc(); cyc();
        chk("mid_rst_nostrobe", {14'd0, R_OUT_T, R_OUT_F}, 16'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            RST    = ($urandom_range(0, 199) == 0);
            EN     = ($urandom_range(0, 9) != 0);
            R_IN_D = ($urandom_range(0, 99) < 55);
            R_IN_C = ($urandom_range(0, 99) < 50);
            D_IN   = N'($urandom);
            C_IN   = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
